// File: rtl/countdown_6bit_pkg.sv
// Shared constants for the loadable down-counter: default width and FSM state encoding.
package countdown_6bit_pkg;

   localparam int CD_WIDTH = 6;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/countdown_6bit.sv
// Loadable down-counter / interval timer with one-cycle terminal-count pulse,
// one-shot (stop at zero) or periodic (auto-reload) operation.
module countdown_6bit
   import countdown_6bit_pkg::*;
#(
   parameter int WIDTH = CD_WIDTH
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] d_in,
   input  logic             en,
   input  logic             auto_reload,
   output logic [WIDTH-1:0] q_out,
   output logic             tc,
   output logic             busy,
   output logic             done
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             tc_q, tc_d;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= ST_IDLE;
         count_q  <= '0;
         reload_q <= '0;
         tc_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         tc_q     <= tc_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      tc_d     = 1'b0;
      if (clr) begin
         count_d = '0;
         state_d = ST_IDLE;
      end else if (load) begin
         count_d  = d_in;
         reload_d = d_in;
         state_d  = (d_in != '0) ? ST_RUN : ST_IDLE;
      end else begin
         case (state_q)
            ST_RUN: begin
               // A zero count while running should never happen; fall back to idle quietly.
               if (count_q == '0) begin
                  state_d = ST_IDLE;
               end else if (en) begin
                  if (count_q == WIDTH'(1)) begin
                     tc_d = 1'b1;
                     if (auto_reload) begin
                        count_d = reload_q;
                     end else begin
                        count_d = '0;
                        state_d = ST_DONE;
                     end
                  end else begin
                     count_d = count_q - WIDTH'(1);
                  end
               end
            end
            ST_IDLE, ST_DONE: ;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign q_out = count_q;
   assign tc    = tc_q;
   assign busy  = (state_q == ST_RUN);
   assign done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_countdown_6bit.sv
// Self-checking bench for countdown_6bit: vector table through a scoreboard queue,
// plus hand-written async-reset and full-range sequences.
module tb_countdown_6bit;

   logic       clk = 1'b0;
   logic       resetn, clr, load, en, auto_reload;
   logic [5:0] d_in;
   logic [5:0] q_out;
   logic       tc, busy, done;

   int tests = 0;
   int fails = 0;

   typedef struct {
      string      name;
      logic       clr, load;
      logic [5:0] d;
      logic       en, ar;
      logic [5:0] q;
      logic       tc, busy, done;
   } vec_t;

   vec_t tbl[$];
   vec_t sb[$];

   countdown_6bit #(.WIDTH(6)) dut (
      .clk(clk), .resetn(resetn), .clr(clr), .load(load), .d_in(d_in),
      .en(en), .auto_reload(auto_reload), .q_out(q_out), .tc(tc),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(string n, logic c, logic l, logic [5:0] d, logic e, logic a,
                               logic [5:0] q, logic t, logic b, logic dn);
      vec_t v;
      v.name = n; v.clr = c; v.load = l; v.d = d; v.en = e; v.ar = a;
      v.q = q; v.tc = t; v.busy = b; v.done = dn;
      return v;
   endfunction

   task automatic compare(string n, logic [5:0] eq, logic et, logic eb, logic ed);
      tests++;
      if (q_out !== eq || tc !== et || busy !== eb || done !== ed) begin
         fails++;
         $display("FAIL %s: got q=%0d tc=%b busy=%b done=%b, want q=%0d tc=%b busy=%b done=%b",
                  n, q_out, tc, busy, done, eq, et, eb, ed);
      end
   endtask

   // Drive on the falling edge, record expectation, check just after the rising edge.
   task automatic step(vec_t v);
      vec_t e;
      @(negedge clk);
      clr = v.clr; load = v.load; d_in = v.d; en = v.en; auto_reload = v.ar;
      sb.push_back(v);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      compare(e.name, e.q, e.tc, e.busy, e.done);
   endtask

   initial begin
      resetn = 1'b0; clr = 1'b0; load = 1'b0; en = 1'b0; auto_reload = 1'b0; d_in = '0;
      #12;
      compare("reset", 6'd0, 1'b0, 1'b0, 1'b0);

      // one-shot from 5
      tbl.push_back(mk("os_load5", 0,1,6'd5,1,0, 6'd5,0,1,0));
      tbl.push_back(mk("os_4",     0,0,6'd0,1,0, 6'd4,0,1,0));
      tbl.push_back(mk("os_3",     0,0,6'd0,1,0, 6'd3,0,1,0));
      tbl.push_back(mk("os_2",     0,0,6'd0,1,0, 6'd2,0,1,0));
      tbl.push_back(mk("os_1",     0,0,6'd0,1,0, 6'd1,0,1,0));
      tbl.push_back(mk("os_tc",    0,0,6'd0,1,0, 6'd0,1,0,1));
      tbl.push_back(mk("os_hold1", 0,0,6'd0,1,0, 6'd0,0,0,1));
      tbl.push_back(mk("os_hold2", 0,0,6'd0,1,0, 6'd0,0,0,1));
      // periodic from 3
      tbl.push_back(mk("ar_load3", 0,1,6'd3,1,1, 6'd3,0,1,0));
      for (int k = 0; k < 3; k++) begin
         tbl.push_back(mk("ar_2",  0,0,6'd0,1,1, 6'd2,0,1,0));
         tbl.push_back(mk("ar_1",  0,0,6'd0,1,1, 6'd1,0,1,0));
         tbl.push_back(mk("ar_tc", 0,0,6'd0,1,1, 6'd3,1,1,0));
      end
      // gated enable from 4
      tbl.push_back(mk("en_load4", 0,1,6'd4,0,0, 6'd4,0,1,0));
      tbl.push_back(mk("en_3",     0,0,6'd0,1,0, 6'd3,0,1,0));
      tbl.push_back(mk("en_h3",    0,0,6'd0,0,0, 6'd3,0,1,0));
      tbl.push_back(mk("en_2",     0,0,6'd0,1,0, 6'd2,0,1,0));
      tbl.push_back(mk("en_h2",    0,0,6'd0,0,0, 6'd2,0,1,0));
      tbl.push_back(mk("en_1",     0,0,6'd0,1,0, 6'd1,0,1,0));
      tbl.push_back(mk("en_h1",    0,0,6'd0,0,0, 6'd1,0,1,0));
      tbl.push_back(mk("en_tc",    0,0,6'd0,1,0, 6'd0,1,0,1));
      // load beats terminal count; clr beats load
      tbl.push_back(mk("pr_load2", 0,1,6'd2,1,0, 6'd2,0,1,0));
      tbl.push_back(mk("pr_1",     0,0,6'd0,1,0, 6'd1,0,1,0));
      tbl.push_back(mk("pr_load7", 0,1,6'd7,1,0, 6'd7,0,1,0));
      tbl.push_back(mk("pr_clr",   1,1,6'd9,1,0, 6'd0,0,0,0));
      tbl.push_back(mk("pr_idle",  0,0,6'd0,1,0, 6'd0,0,0,0));
      // load zero stays idle
      tbl.push_back(mk("z_load0",  0,1,6'd0,1,0, 6'd0,0,0,0));
      tbl.push_back(mk("z_idle",   0,0,6'd0,1,1, 6'd0,0,0,0));
      // auto_reload only matters on the terminal cycle
      tbl.push_back(mk("am_load2", 0,1,6'd2,1,1, 6'd2,0,1,0));
      tbl.push_back(mk("am_1",     0,0,6'd0,1,0, 6'd1,0,1,0));
      tbl.push_back(mk("am_rl",    0,0,6'd0,1,1, 6'd2,1,1,0));
      tbl.push_back(mk("am_1b",    0,0,6'd0,1,0, 6'd1,0,1,0));
      tbl.push_back(mk("am_stop",  0,0,6'd0,1,0, 6'd0,1,0,1));

      @(negedge clk);
      resetn = 1'b1;
      for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

      // async reset mid-count at 9
      step(mk("rs_load12", 0,1,6'd12,0,0, 6'd12,0,1,0));
      step(mk("rs_11",     0,0,6'd0,1,0,  6'd11,0,1,0));
      step(mk("rs_10",     0,0,6'd0,1,0,  6'd10,0,1,0));
      step(mk("rs_9",      0,0,6'd0,1,0,  6'd9,0,1,0));
      #2 resetn = 1'b0;
      #1 compare("async_reset", 6'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      resetn = 1'b1;
      step(mk("rs_after", 0,0,6'd0,1,0, 6'd0,0,0,0));

      // drive into DONE, then full-range count from 63
      step(mk("f_load1", 0,1,6'd1,1,0, 6'd1,0,1,0));
      step(mk("f_done",  0,0,6'd0,1,0, 6'd0,1,0,1));
      step(mk("f_load63", 0,1,6'd63,1,0, 6'd63,0,1,0));
      for (int i = 62; i >= 0; i--)
         step(mk("f_cnt", 0,0,6'd0,1,0, 6'(i), (i == 0), (i != 0), (i == 0)));
      step(mk("f_nowrap", 0,0,6'd0,1,0, 6'd0,0,0,1));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
